step_period_meter: RTL and testbench

- Inverse of the stepper frequency generator: measures the half-period of an incoming step/square wave and recovers the 24-bit Pitch count that would regenerate it.
- Used for closed-loop checking of stepper output pins, and for capturing an external step source as a Pitch value.
- Sits between a pin input and any consumer of Pitch words.

---
 rtl/step_period_meter.sv | 185 ++++++++++++++++++
 tb/tb_step_period_meter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_period_meter.sv
// step_period_meter
//
// Measures the half-period of an incoming step/square wave and recovers the
// Pitch count a stepper frequency generator would need to reproduce it. The
// generator toggles its pin every Pitch+2 clocks, so a measured half-period
// of H clocks maps back to Pitch = H - 2.
//
// Ports:
//   Clk          system clock
//   Rst_n        asynchronous active-low reset
//   Step_in      asynchronous square wave to measure
//   Pitch_out    recovered Pitch, 0 while silent/unlocked
//   Pitch_valid  one-cycle pulse on every Pitch_out update
//   Locked       high while measurements are being produced
//   Glitch       one-cycle pulse when a too-short interval is rejected
//   Timeout      one-cycle pulse when the input goes silent
//
// Optional feature (macro STEP_PERIOD_AVG_EN): Pitch_out is derived from the
// average of the two most recent accepted half-periods, which cancels
// duty-cycle asymmetry in external sources. A fresh pair of intervals is
// needed after arming and after every glitch before updates resume.

module step_period_meter #(
   parameter int               WIDTH    = 24,
   parameter logic [WIDTH-1:0] TIMEOUT  = 24'hFFFFFF,
   parameter logic [WIDTH-1:0] MIN_HALF = WIDTH'(3)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Step_in,
   output logic [WIDTH-1:0] Pitch_out,
   output logic             Pitch_valid,
   output logic             Locked,
   output logic             Glitch,
   output logic             Timeout
);

   typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = TIMEOUT - WIDTH'(1);

   state_t           state;
   state_t           state_next;
   logic             s1, s2, s3;
   logic             step_edge;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] h;
   logic             accept;
   logic             at_limit;
   logic [WIDTH-1:0] pitch_d;
   logic             valid_d;
   logic             glitch_d;
   logic             timeout_d;

`ifdef STEP_PERIOD_AVG_EN
   logic [WIDTH-1:0] h_prev;
   logic [WIDTH-1:0] h_prev_d;
   logic             prime;
   logic             prime_d;
   logic [WIDTH:0]   h_sum;
   logic [WIDTH-1:0] avg_pitch;

   // The sum is one bit wider so two large intervals cannot overflow
   // before the halving.
   assign h_sum     = {1'b0, h_prev} + {1'b0, h};
   assign avg_pitch = h_sum[WIDTH:1] - WIDTH'(2);
`endif

   // Two flops resolve metastability; the third gives the previous sample
   // so both rising and falling edges are seen. The fixed delay is the same
   // for every edge and so drops out of the interval.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= Step_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign step_edge = s2 ^ s3;
   assign h         = cnt + WIDTH'(1);
   assign accept    = (h >= MIN_HALF);
   assign at_limit  = (cnt == CNT_MAX);
   assign Locked    = (state == LOCKED);

   // State register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic. An edge always takes priority over the timeout, so a
   // measurement landing on the saturation cycle is still accepted.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (step_edge) state_next = ARMED;
         end
         ARMED: begin
            if (step_edge) begin
               if (accept) state_next = LOCKED;
            end else if (at_limit) begin
               state_next = IDLE;
            end
         end
         LOCKED: begin
            if (!step_edge && at_limit) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: computes the values the output registers take next.
   // Pitch_out holds unless an accepted measurement or a timeout changes it.
   always_comb begin
      pitch_d   = Pitch_out;
      valid_d   = 1'b0;
      glitch_d  = 1'b0;
      timeout_d = 1'b0;
`ifdef STEP_PERIOD_AVG_EN
      h_prev_d  = h_prev;
      prime_d   = prime;
`endif
      if (state != IDLE) begin
         if (step_edge) begin
            if (accept) begin
`ifdef STEP_PERIOD_AVG_EN
               // The first good interval after arming or a glitch has no
               // partner to average with, so it only seeds h_prev.
               h_prev_d = h;
               prime_d  = 1'b0;
               if (state == LOCKED && !prime) begin
                  pitch_d = avg_pitch;
                  valid_d = 1'b1;
               end
`else
               pitch_d = cnt - WIDTH'(1);
               valid_d = 1'b1;
`endif
            end else begin
               glitch_d = 1'b1;
`ifdef STEP_PERIOD_AVG_EN
               prime_d  = 1'b1;
`endif
            end
         end else if (at_limit) begin
            pitch_d   = '0;
            timeout_d = 1'b1;
         end
      end
   end

   // Interval counter and registered outputs. The counter restarts on every
   // edge, is held at zero while idle, and saturates rather than wrapping.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt         <= '0;
         Pitch_out   <= '0;
         Pitch_valid <= 1'b0;
         Glitch      <= 1'b0;
         Timeout     <= 1'b0;
`ifdef STEP_PERIOD_AVG_EN
         h_prev      <= '0;
         prime       <= 1'b0;
`endif
      end else begin
         if (step_edge || state == IDLE) cnt <= '0;
         else if (!at_limit)             cnt <= cnt + WIDTH'(1);
         Pitch_out   <= pitch_d;
         Pitch_valid <= valid_d;
         Glitch      <= glitch_d;
         Timeout     <= timeout_d;
`ifdef STEP_PERIOD_AVG_EN
         h_prev      <= h_prev_d;
         prime       <= prime_d;
`endif
      end
   end

endmodule

// File: tb/tb_step_period_meter.sv
// tb_step_period_meter
//
// Directed bench for step_period_meter. TIMEOUT is shortened to 1200 clocks
// so silence detection finishes quickly while 1002-clock half-periods are
// still measurable. Step_in changes 1 ns after a rising clock edge; outputs
// are sampled 1 ns after a rising edge or by the falling-edge monitor.

module tb_step_period_meter;

   localparam int         WIDTH   = 24;
   localparam logic [23:0] TO_CLKS = 24'd1200;

   logic             Clk     = 1'b0;
   logic             Rst_n   = 1'b0;
   logic             Step_in = 1'b0;
   logic [WIDTH-1:0] Pitch_out;
   logic             Pitch_valid;
   logic             Locked;
   logic             Glitch;
   logic             Timeout;

   int total = 0;
   int bad   = 0;

   int               cyc         = 0;
   int               valid_cnt   = 0;
   int               glitch_cnt  = 0;
   int               timeout_cnt = 0;
   int               valid_cyc   = 0;
   int               to_cyc      = 0;
   logic [WIDTH-1:0] last_pitch  = '0;
   logic [WIDTH-1:0] to_pitch    = '0;
   logic             to_locked   = 1'b0;
   logic             to_valid    = 1'b0;

   step_period_meter #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TO_CLKS)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Step_in     (Step_in),
      .Pitch_out   (Pitch_out),
      .Pitch_valid (Pitch_valid),
      .Locked      (Locked),
      .Glitch      (Glitch),
      .Timeout     (Timeout)
   );

   always #5 Clk = ~Clk;

   // Free-running cycle count used to time pulses against each other.
   always @(posedge Clk) cyc <= cyc + 1;

   // Pulse monitor: tallies every output pulse and records what accompanied it.
   always @(negedge Clk) begin
      if (Pitch_valid) begin
         valid_cnt  <= valid_cnt + 1;
         last_pitch <= Pitch_out;
         valid_cyc  <= cyc;
      end
      if (Glitch) glitch_cnt <= glitch_cnt + 1;
      if (Timeout) begin
         timeout_cnt <= timeout_cnt + 1;
         to_cyc      <= cyc;
         to_pitch    <= Pitch_out;
         to_locked   <= Locked;
         to_valid    <= Pitch_valid;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // Wait k clocks then toggle the pin, so the toggle ends a k-clock interval.
   task automatic edge_after(input int k);
      tick(k);
      Step_in = ~Step_in;
   endtask

   task automatic test_reset();
      Rst_n   = 1'b0;
      Step_in = 1'b0;
      tick(3);
      total++; if (Pitch_out !== 24'd0) begin bad++; $display("[TB] FAIL reset_pitch: got %0d want 0", Pitch_out); end
      total++; if (Pitch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", Pitch_valid); end
      total++; if (Locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %b want 0", Locked); end
      total++; if (Glitch !== 1'b0) begin bad++; $display("[TB] FAIL reset_glitch: got %b want 0", Glitch); end
      total++; if (Timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", Timeout); end
      Rst_n = 1'b1;
      tick(3);
   endtask

   // 12-clock half-periods: first edge arms, each later edge yields Pitch 10.
   task automatic test_lock();
      int v0, g0;
      v0 = valid_cnt;
      g0 = glitch_cnt;
      edge_after(2);
      edge_after(12);
      edge_after(12);
      edge_after(12);
      tick(4);
      total++; if (valid_cnt - v0 != 3) begin bad++; $display("[TB] FAIL lock_valid_count: got %0d want 3", valid_cnt - v0); end
      total++; if (last_pitch !== 24'd10) begin bad++; $display("[TB] FAIL lock_pitch: got %0d want 10", last_pitch); end
      total++; if (Pitch_out !== 24'd10) begin bad++; $display("[TB] FAIL lock_pitch_hold: got %0d want 10", Pitch_out); end
      total++; if (Locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_locked: got %b want 1", Locked); end
      total++; if (glitch_cnt - g0 != 0) begin bad++; $display("[TB] FAIL lock_glitch: got %0d want 0", glitch_cnt - g0); end
   endtask

   // Pitch_valid must appear in the fourth cycle counting the toggle cycle.
   task automatic test_latency();
      edge_after(8);
      tick(2);
      total++; if (Pitch_valid !== 1'b0) begin bad++; $display("[TB] FAIL latency_early: got %b want 0", Pitch_valid); end
      tick(1);
      total++; if (Pitch_valid !== 1'b1) begin bad++; $display("[TB] FAIL latency_pulse: got %b want 1", Pitch_valid); end
      total++; if (Pitch_out !== 24'd10) begin bad++; $display("[TB] FAIL latency_pitch: got %0d want 10", Pitch_out); end
      tick(1);
      total++; if (Pitch_valid !== 1'b0) begin bad++; $display("[TB] FAIL latency_one_cycle: got %b want 0", Pitch_valid); end
   endtask

   // Switch from 12- to 1002-clock half-periods.
   task automatic test_switch();
      int v0, g0;
      v0 = valid_cnt;
      g0 = glitch_cnt;
      edge_after(8);
      edge_after(1002);
      tick(4);
      total++; if (valid_cnt - v0 != 2) begin bad++; $display("[TB] FAIL switch_valid_count: got %0d want 2", valid_cnt - v0); end
      total++; if (last_pitch !== 24'd1000) begin bad++; $display("[TB] FAIL switch_pitch: got %0d want 1000", last_pitch); end
      total++; if (glitch_cnt - g0 != 0) begin bad++; $display("[TB] FAIL switch_glitch: got %0d want 0", glitch_cnt - g0); end
   endtask

   // A 1-clock spike right after a good edge gives two 1-clock intervals.
   task automatic test_glitch();
      int v0, g0;
      v0 = valid_cnt;
      g0 = glitch_cnt;
      edge_after(8);
      edge_after(1);
      edge_after(1);
      tick(6);
      total++; if (glitch_cnt - g0 != 2) begin bad++; $display("[TB] FAIL glitch_count: got %0d want 2", glitch_cnt - g0); end
      total++; if (valid_cnt - v0 != 1) begin bad++; $display("[TB] FAIL glitch_valid_count: got %0d want 1", valid_cnt - v0); end
      total++; if (Pitch_out !== 24'd10) begin bad++; $display("[TB] FAIL glitch_pitch_hold: got %0d want 10", Pitch_out); end
      total++; if (Locked !== 1'b1) begin bad++; $display("[TB] FAIL glitch_locked: got %b want 1", Locked); end
      edge_after(6);
      tick(4);
      total++; if (valid_cnt - v0 != 2) begin bad++; $display("[TB] FAIL glitch_recover_count: got %0d want 2", valid_cnt - v0); end
      edge_after(16);
      tick(4);
      total++; if (last_pitch !== 24'd18) begin bad++; $display("[TB] FAIL glitch_recover_pitch: got %0d want 18", last_pitch); end
   endtask

   // Stop the input while locked; expect one Timeout exactly TIMEOUT clocks
   // after the last Pitch_valid.
   task automatic test_timeout();
      int t0, v0;
      t0 = timeout_cnt;
      v0 = valid_cnt;
      tick(int'(TO_CLKS) + 20);
      total++; if (timeout_cnt - t0 != 1) begin bad++; $display("[TB] FAIL timeout_count: got %0d want 1", timeout_cnt - t0); end
      total++; if (to_cyc - valid_cyc != int'(TO_CLKS)) begin bad++; $display("[TB] FAIL timeout_delay: got %0d want %0d", to_cyc - valid_cyc, TO_CLKS); end
      total++; if (to_pitch !== 24'd0) begin bad++; $display("[TB] FAIL timeout_pitch: got %0d want 0", to_pitch); end
      total++; if (to_locked !== 1'b0) begin bad++; $display("[TB] FAIL timeout_locked: got %b want 0", to_locked); end
      total++; if (to_valid !== 1'b0) begin bad++; $display("[TB] FAIL timeout_valid: got %b want 0", to_valid); end
      total++; if (valid_cnt - v0 != 0) begin bad++; $display("[TB] FAIL timeout_no_valid: got %0d want 0", valid_cnt - v0); end
      total++; if (Locked !== 1'b0) begin bad++; $display("[TB] FAIL timeout_idle: got %b want 0", Locked); end
   endtask

   // Reset in the middle of a locked interval.
   task automatic test_reset_mid();
      int v0;
      edge_after(1);
      edge_after(12);
      tick(5);
      Rst_n = 1'b0;
      #1;
      total++; if (Pitch_out !== 24'd0) begin bad++; $display("[TB] FAIL midreset_pitch: got %0d want 0", Pitch_out); end
      total++; if (Locked !== 1'b0) begin bad++; $display("[TB] FAIL midreset_locked: got %b want 0", Locked); end
      Step_in = 1'b0;
      tick(3);
      Rst_n = 1'b1;
      tick(3);
      v0 = valid_cnt;
      edge_after(1);
      tick(4);
      total++; if (valid_cnt - v0 != 0) begin bad++; $display("[TB] FAIL midreset_first_edge: got %0d want 0", valid_cnt - v0); end
      total++; if (Pitch_out !== 24'd0) begin bad++; $display("[TB] FAIL midreset_first_pitch: got %0d want 0", Pitch_out); end
      edge_after(8);
      tick(4);
      total++; if (valid_cnt - v0 != 1) begin bad++; $display("[TB] FAIL midreset_second_edge: got %0d want 1", valid_cnt - v0); end
      total++; if (Pitch_out !== 24'd10) begin bad++; $display("[TB] FAIL midreset_pitch_after: got %0d want 10", Pitch_out); end
   endtask

`ifdef STEP_PERIOD_AVG_EN
   // Alternating 12/14 half-periods average to 13, i.e. Pitch 11.
   task automatic test_avg();
      int v0;
      v0 = valid_cnt;
      edge_after(2);
      edge_after(12);
      tick(4);
      total++; if (valid_cnt - v0 != 0) begin bad++; $display("[TB] FAIL avg_prime_valid: got %0d want 0", valid_cnt - v0); end
      total++; if (Locked !== 1'b1) begin bad++; $display("[TB] FAIL avg_locked: got %b want 1", Locked); end
      edge_after(10);
      tick(4);
      total++; if (last_pitch !== 24'd11) begin bad++; $display("[TB] FAIL avg_pitch_first: got %0d want 11", last_pitch); end
      edge_after(8);
      edge_after(14);
      tick(4);
      total++; if (valid_cnt - v0 != 3) begin bad++; $display("[TB] FAIL avg_valid_count: got %0d want 3", valid_cnt - v0); end
      total++; if (last_pitch !== 24'd11) begin bad++; $display("[TB] FAIL avg_pitch_last: got %0d want 11", last_pitch); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef STEP_PERIOD_AVG_EN
      test_avg();
`else
      test_lock();
      test_latency();
      test_switch();
      test_glitch();
      test_timeout();
      test_reset_mid();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
